// File: rtl/multiplier_pipelined_pkg.sv
// Shared constants and saturation-limit helpers for the pipelined multiplier family.
// Limits are returned 64 bits wide; callers slice them down to their WIDTH.
package multiplier_pipelined_pkg;

    localparam int PIPE_LATENCY = 3;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

    function automatic logic [63:0] sat_max(input int width, input mode_e mode);
        logic [63:0] ones;
        ones = '1;
        if (mode == MODE_SIGNED) begin
            return ones >> (65 - width);
        end
        return ones >> (64 - width);
    endfunction

    function automatic logic [63:0] sat_min_signed(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/multiplier_pipelined_if.sv
// Operand/result valid-ready bundle for the pipelined multiplier.
// The master drives operands and out_ready; the slave returns in_ready and the result.
interface multiplier_pipelined_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p;
    logic             overflow;

    modport master (
        output in_valid, is_signed, a, b, out_ready,
        input  in_ready, out_valid, p, overflow
    );

    modport slave (
        input  in_valid, is_signed, a, b, out_ready,
        output in_ready, out_valid, p, overflow
    );
endinterface

// File: rtl/multiplier_pipelined_mult_scale_sat.sv
// Combinational round / shift / saturate of a full product to WIDTH bits; zero latency.
// No flow control of its own: the enclosing pipeline register decides when to capture.
module mult_scale_sat
    import multiplier_pipelined_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int FRAC_BITS = 0,
    parameter bit ROUND     = 1'b1
) (
    input  logic signed [2*WIDTH+1:0] i_prod,
    input  mode_e                     i_mode,
    output logic        [WIDTH-1:0]   o_p,
    output logic                      o_overflow
);
    localparam int          QW      = 2*WIDTH + 3;
    localparam logic [63:0] L_MAX_U = sat_max(WIDTH, MODE_UNSIGNED);
    localparam logic [63:0] L_MAX_S = sat_max(WIDTH, MODE_SIGNED);
    localparam logic [63:0] L_MIN_S = sat_min_signed(WIDTH);

    logic signed [QW-1:0] w_ext;
    logic signed [QW-1:0] w_bias;
    logic signed [QW-1:0] w_q;
    logic                 w_hi_zero_u;
    logic                 w_hi_zero_s;
    logic                 w_hi_ones_s;

    // One guard bit so a rounding carry can never wrap before saturation sees it.
    assign w_ext = {i_prod[2*WIDTH+1], i_prod};

    generate
        if (ROUND && FRAC_BITS > 0) begin : g_round
            assign w_bias = {{(QW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
        end else begin : g_trunc
            assign w_bias = '0;
        end
    endgenerate

    // Unsigned products are zero-extended and never negative, so >>> acts as a logical shift.
    assign w_q = (w_ext + w_bias) >>> FRAC_BITS;

    assign w_hi_zero_u = ~|w_q[QW-1:WIDTH];
    assign w_hi_zero_s = ~|w_q[QW-1:WIDTH-1];
    assign w_hi_ones_s = &w_q[QW-1:WIDTH-1];

    always_comb begin
        o_p        = w_q[WIDTH-1:0];
        o_overflow = 1'b0;
        if (i_mode == MODE_SIGNED) begin
            if (!(w_hi_zero_s || w_hi_ones_s)) begin
                o_overflow = 1'b1;
                o_p        = w_q[QW-1] ? L_MIN_S[WIDTH-1:0] : L_MAX_S[WIDTH-1:0];
            end
        end else if (!w_hi_zero_u) begin
            o_overflow = 1'b1;
            o_p        = L_MAX_U[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/multiplier_pipelined.sv
// 3-stage WIDTH x WIDTH fixed-point multiplier (extend, multiply, scale/saturate); latency 3, 1/cycle.
// A held result (out_valid && !out_ready) freezes every stage and drops in_ready combinationally.
module multiplier_pipelined
    import multiplier_pipelined_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int FRAC_BITS = 0,
    parameter bit ROUND     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multiplier_pipelined_if.slave bus
);
    localparam int PW = 2*WIDTH + 2;

    logic                    r_s1_vld;
    logic signed [WIDTH:0]   r_s1_a;
    logic signed [WIDTH:0]   r_s1_b;
    mode_e                   r_s1_mode;

    logic                    r_s2_vld;
    logic signed [PW-1:0]    r_s2_prod;
    mode_e                   r_s2_mode;

    logic                    r_s3_vld;
    logic        [WIDTH-1:0] r_p;
    logic                    r_ovf;

    logic                    w_stall;
    logic                    w_adv;
    logic signed [PW-1:0]    w_a_ext;
    logic signed [PW-1:0]    w_b_ext;
    logic signed [PW-1:0]    w_prod;
    logic        [WIDTH-1:0] w_p;
    logic                    w_ovf;

    assign w_stall       = r_s3_vld && !bus.out_ready;
    assign w_adv         = !w_stall;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_s3_vld;
    assign bus.p         = r_p;
    assign bus.overflow  = r_ovf;

    // Operands are already extended per mode, so a single signed multiply covers both.
    assign w_a_ext = {{(WIDTH+1){r_s1_a[WIDTH]}}, r_s1_a};
    assign w_b_ext = {{(WIDTH+1){r_s1_b[WIDTH]}}, r_s1_b};
    assign w_prod  = w_a_ext * w_b_ext;

    mult_scale_sat #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .ROUND     (ROUND)
    ) u_scale_sat (
        .i_prod     (r_s2_prod),
        .i_mode     (r_s2_mode),
        .o_p        (w_p),
        .o_overflow (w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_mode <= MODE_UNSIGNED;
            r_s2_vld  <= 1'b0;
            r_s2_prod <= '0;
            r_s2_mode <= MODE_UNSIGNED;
            r_s3_vld  <= 1'b0;
            r_p       <= '0;
            r_ovf     <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld  <= bus.in_valid;
            r_s1_a    <= {bus.is_signed & bus.a[WIDTH-1], bus.a};
            r_s1_b    <= {bus.is_signed & bus.b[WIDTH-1], bus.b};
            r_s1_mode <= mode_e'(bus.is_signed);
            r_s2_vld  <= r_s1_vld;
            r_s2_prod <= w_prod;
            r_s2_mode <= r_s1_mode;
            r_s3_vld  <= r_s2_vld;
            r_p       <= w_p;
            r_ovf     <= w_ovf;
        end
    end

endmodule

// File: tb/tb_multiplier_pipelined.sv
// Drives three multiplier configurations (F0/R1, F32/R1, F32/R0) with one shared stream
// and checks every result against an arbitrary-precision integer model.
module tb_multiplier_pipelined;
    import multiplier_pipelined_pkg::*;

    localparam int W = 64;
    typedef logic [2:0][64:0]      trip_t;
    typedef logic signed [199:0]   big_t;
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        sgn;
    } vec_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        d_vld  = 1'b0;
    logic        d_sgn  = 1'b0;
    logic        d_ordy = 1'b0;
    logic [63:0] d_a    = '0;
    logic [63:0] d_b    = '0;

    int    n_chk = 0;
    int    n_err = 0;
    logic  s_vld;
    trip_t expq[$];
    trip_t outlog[$];
    logic [2:0] prev_stall = '0;
    trip_t      prev_out;

    logic [2:0]  ov_vld, ov_ovf, ov_irdy;
    logic [63:0] ov_p [3];

    always #5 clk = ~clk;

    multiplier_pipelined_if #(.WIDTH(W)) if0 ();
    multiplier_pipelined_if #(.WIDTH(W)) if1 ();
    multiplier_pipelined_if #(.WIDTH(W)) if2 ();

    multiplier_pipelined #(.WIDTH(W), .FRAC_BITS(0),  .ROUND(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    multiplier_pipelined #(.WIDTH(W), .FRAC_BITS(32), .ROUND(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    multiplier_pipelined #(.WIDTH(W), .FRAC_BITS(32), .ROUND(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    assign if0.in_valid = d_vld;  assign if1.in_valid = d_vld;  assign if2.in_valid = d_vld;
    assign if0.is_signed = d_sgn; assign if1.is_signed = d_sgn; assign if2.is_signed = d_sgn;
    assign if0.a = d_a;           assign if1.a = d_a;           assign if2.a = d_a;
    assign if0.b = d_b;           assign if1.b = d_b;           assign if2.b = d_b;
    assign if0.out_ready = d_ordy; assign if1.out_ready = d_ordy; assign if2.out_ready = d_ordy;

    assign ov_vld  = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign ov_ovf  = {if2.overflow,  if1.overflow,  if0.overflow};
    assign ov_irdy = {if2.in_ready,  if1.in_ready,  if0.in_ready};
    assign ov_p[0] = if0.p;
    assign ov_p[1] = if1.p;
    assign ov_p[2] = if2.p;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact integer arithmetic: extend, multiply, round, floor-shift, clamp to range.
    function automatic logic [64:0] ref_one(input logic [63:0] a, input logic [63:0] b,
                                            input logic sgn, input int frac, input bit rnd);
        big_t va, vb, prod, q, hi, lo, one;
        one  = 1;
        va   = {{136{sgn & a[63]}}, a};
        vb   = {{136{sgn & b[63]}}, b};
        prod = va * vb;
        if (rnd && frac > 0) prod = prod + (one <<< (frac - 1));
        q  = prod >>> frac;
        hi = sgn ? (one <<< (W - 1)) - one : (one <<< W) - one;
        lo = sgn ? -(one <<< (W - 1)) : big_t'(0);
        if (q > hi) return {1'b1, hi[63:0]};
        if (q < lo) return {1'b1, lo[63:0]};
        return {1'b0, q[63:0]};
    endfunction

    function automatic trip_t ref_all(input logic [63:0] a, input logic [63:0] b, input logic sgn);
        trip_t t;
        t[0] = ref_one(a, b, sgn, 0, 1'b1);
        t[1] = ref_one(a, b, sgn, 32, 1'b1);
        t[2] = ref_one(a, b, sgn, 32, 1'b0);
        return t;
    endfunction

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = 64'($urandom_range(0, 255)) - 64'd128;
            2: v = {$urandom, $urandom} >> $urandom_range(0, 63);
            default: begin
                case ($urandom_range(0, 3))
                    0: v = 64'h8000_0000_0000_0000;
                    1: v = 64'h7FFF_FFFF_FFFF_FFFF;
                    2: v = '1;
                    default: v = 64'd1;
                endcase
            end
        endcase
        return v;
    endfunction

    // One clock: drive at posedge+1, observe at negedge, return at next posedge+1.
    task automatic cycle(input bit iv, input logic [63:0] ia, input logic [63:0] ib,
                         input bit isg, input bit ordy, output bit acc);
        trip_t e, got;
        d_vld = iv; d_a = ia; d_b = ib; d_sgn = isg; d_ordy = ordy;
        @(negedge clk);
        for (int k = 0; k < 3; k++) got[k] = {ov_ovf[k], ov_p[k]};
        for (int k = 0; k < 3; k++)
            if (prev_stall[k]) check($sformatf("hold_while_stalled[%0d]", k), got[k], prev_out[k]);
        check("in_ready", 65'(ov_irdy[0]), 65'(!(ov_vld[0] && !ordy)));
        s_vld = ov_vld[0];
        if (ov_vld[0] && ordy) begin
            if (expq.size() == 0) begin
                check("spurious_output", 65'(ov_vld[0]), 65'd0);
            end else begin
                e = expq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("valid_aligned[%0d]", k), 65'(ov_vld[k]), 65'd1);
                    check($sformatf("result[%0d]", k), got[k], e[k]);
                end
                outlog.push_back(got);
            end
        end
        acc = iv && ov_irdy[0];
        if (acc) expq.push_back(ref_all(ia, ib, isg));
        for (int k = 0; k < 3; k++) prev_stall[k] = ov_vld[k] && !ordy;
        prev_out = got;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit acc;
        int budget;
        budget = 300;
        while (expq.size() > 0 && budget > 0) begin
            cycle(1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)), acc);
            budget--;
        end
        check("drain_empty", 65'(expq.size()), 65'd0);
    endtask

    initial begin
        bit   acc;
        int   start, budget, nacc;
        vec_t dv [6];

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_valid[%0d]", k), 65'(ov_vld[k]), 65'd0);
            check($sformatf("reset_p_ovf[%0d]", k), {ov_ovf[k], ov_p[k]}, 65'd0);
        end
        reset = 1'b0;
        #1 check("in_ready_after_reset", 65'(ov_irdy[0]), 65'd1);

        // Unsigned 8*8 with exact latency.
        cycle(1'b1, 64'd8, 64'd8, 1'b0, 1'b1, acc);
        check("accept_first", 65'(acc), 65'd1);
        for (int i = 1; i <= PIPE_LATENCY; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
            check($sformatf("latency_cycle%0d", i), 65'(s_vld), 65'(i == PIPE_LATENCY));
        end

        dv[0] = '{a: 64'hFFFF_FFFF_FFFF_FFFD, b: 64'd5, sgn: 1'b1};
        dv[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFD, b: 64'd5, sgn: 1'b0};
        dv[2] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, sgn: 1'b1};
        dv[3] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, sgn: 1'b1};
        dv[4] = '{a: 64'h1_8000_0000, b: 64'h2_0000_0000, sgn: 1'b1};
        dv[5] = '{a: 64'd1, b: 64'h8000_0000, sgn: 1'b1};
        for (int i = 0; i < 6; i++) cycle(1'b1, dv[i].a, dv[i].b, dv[i].sgn, 1'b1, acc);
        drain();
        check("directed_count", 65'(outlog.size()), 65'd7);
        check("u8x8",           outlog[0][0], {1'b0, 64'd64});
        check("s_m3x5",         outlog[1][0], {1'b0, 64'hFFFF_FFFF_FFFF_FFF1});
        check("u_m3x5_sat",     outlog[2][0], {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        check("s_min_sq_sat",   outlog[3][0], {1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
        check("s_min_x1",       outlog[4][0], {1'b0, 64'h8000_0000_0000_0000});
        check("q32_1p5x2_rnd",  outlog[5][1], {1'b0, 64'h3_0000_0000});
        check("q32_1p5x2_trn",  outlog[5][2], {1'b0, 64'h3_0000_0000});
        check("q32_half_rnd",   outlog[6][1], {1'b0, 64'd1});
        check("q32_half_trn",   outlog[6][2], {1'b0, 64'd0});

        // Ten-beat stream under random backpressure.
        start = outlog.size();
        nacc = 0;
        budget = 300;
        while (nacc < 10 && budget > 0) begin
            cycle(1'b1, 64'(nacc), 64'(nacc + 1), 1'b0, 1'($urandom_range(0, 1)), acc);
            if (acc) nacc++;
            budget--;
        end
        check("bp_accepted", 65'(nacc), 65'd10);
        drain();
        check("bp_count", 65'(outlog.size() - start), 65'd10);
        for (int i = 0; i < 10 && start + i < outlog.size(); i++)
            check($sformatf("bp_value%0d", i), outlog[start + i][0], {1'b0, 64'(i * (i + 1))});

        // Random operands, modes, bubbles and stalls.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), acc);
        drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'(i + 3), 64'(i + 11), 1'b0, 1'b1, acc);
        check("inflight_before_reset", 65'(ov_vld[0]), 65'd1);
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("reset_drops_valid[%0d]", k), 65'(ov_vld[k]), 65'd0);
        expq.delete();
        prev_stall = '0;
        cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
            check($sformatf("no_stale_out%0d", i), 65'(s_vld), 65'd0);
        end
        cycle(1'b1, 64'd7, 64'd9, 1'b0, 1'b1, acc);
        check("accept_after_reset", 65'(acc), 65'd1);
        for (int i = 1; i <= PIPE_LATENCY; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
            check($sformatf("latency_after_reset%0d", i), 65'(s_vld), 65'(i == PIPE_LATENCY));
        end
        check("post_reset_value", outlog[outlog.size() - 1][0], {1'b0, 64'd63});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
